// File: rtl/rx_frame_commit.sv
// rx_frame_commit: reassembles descrambled beats into frames and commits frames
// flagged good by the validator into a small frame FIFO. The FIFO drains on an
// AXI-Stream master. The block also drives a pause hint back to TX and counts
// overflow drops and rx_error episodes.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_data_i          descrambled beat (one per cycle)
//   rx_sof_i           first beat of a frame
//   rx_crc_good_i      pulse: current beat ends an in-order good frame
//   rx_error_i         level: upstream rollback in progress
//   m_axis_tdata_o     stripped payload of the FIFO head
//   m_axis_tvalid_o    payload valid
//   m_axis_tready_i    sink ready
//   rx_pause_o         FIFO near full
//   overflow_o         1-cycle pulse when a good frame is dropped
//   drop_cnt_o         saturating overflow drop count
//   retrans_cnt_o      saturating count of rx_error rising edges
module rx_frame_commit #(
  parameter int unsigned FRAME_WIDTH   = 256,
  parameter int unsigned DWIDTH        = 64,
  parameter int unsigned CRC_WIDTH     = 12,
  parameter int unsigned FIFO_FRAMES   = 4,
  parameter int unsigned PAUSE_THRESH  = 1,
  localparam int unsigned PAYLOAD_WIDTH = FRAME_WIDTH - 2 - CRC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DWIDTH-1:0]        rx_data_i,
  input  logic                     rx_sof_i,
  input  logic                     rx_crc_good_i,
  input  logic                     rx_error_i,
  output logic [PAYLOAD_WIDTH-1:0] m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     rx_pause_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic [15:0]              retrans_cnt_o
);

  localparam int unsigned BEATS = FRAME_WIDTH / DWIDTH;
  localparam int unsigned IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTRW  = $clog2(FIFO_FRAMES);
  localparam int unsigned CNTW  = PTRW + 1;

  logic [IDXW-1:0]          idx_q, idx_d, slot_c;
  logic [FRAME_WIDTH-1:0]   asm_q, asm_d;
  logic [PAYLOAD_WIDTH-1:0] mem_q [FIFO_FRAMES];
  logic [PTRW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [PAYLOAD_WIDTH-1:0] tdata_q, tdata_d, push_data_c;
  logic                     tvalid_q, tvalid_d;
  logic                     pause_q, pause_d;
  logic                     ovf_q, ovf_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;
  logic [15:0]              retrans_cnt_q, retrans_cnt_d;
  logic                     err_q;
  logic                     last_c, commit_c, push_c, pop_c, drop_c;

  // Assembly, commit decision, FIFO pointer/count and flag next-state logic
  always_comb begin
    slot_c = rx_sof_i ? '0 : idx_q;
    asm_d  = asm_q;
    // Slot 0 occupies the frame MSBs; later beats fill downward
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (slot_c == IDXW'(b)) asm_d[FRAME_WIDTH-1-b*DWIDTH -: DWIDTH] = rx_data_i;
    end
    idx_d       = (BEATS == 1) ? '0 : slot_c + IDXW'(1);
    last_c      = (slot_c == IDXW'(BEATS - 1));
    commit_c    = last_c & rx_crc_good_i;
    pop_c       = tvalid_q & m_axis_tready_i;
    push_c      = commit_c & ((cnt_q < CNTW'(FIFO_FRAMES)) | pop_c);
    drop_c      = commit_c & ~push_c;
    push_data_c = asm_d[FRAME_WIDTH-3:CRC_WIDTH];

    wptr_d = push_c ? wptr_q + PTRW'(1) : wptr_q;
    rptr_d = pop_c  ? rptr_q + PTRW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push_c && !pop_c) cnt_d = cnt_q + CNTW'(1);
    if (!push_c && pop_c) cnt_d = cnt_q - CNTW'(1);

    // A frame pushed into a slot that becomes the head must bypass the memory
    tdata_d  = (push_c && (rptr_d == wptr_q)) ? push_data_c : mem_q[rptr_d];
    tvalid_d = (cnt_d != '0);
    pause_d  = ((FIFO_FRAMES - 32'(cnt_d)) <= PAUSE_THRESH);
    ovf_d    = drop_c;

    drop_cnt_d = drop_cnt_q;
    if (drop_c && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    retrans_cnt_d = retrans_cnt_q;
    if (rx_error_i && !err_q && retrans_cnt_q != 16'hFFFF) retrans_cnt_d = retrans_cnt_q + 16'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      asm_q         <= '0;
      for (int i = 0; i < int'(FIFO_FRAMES); i++) mem_q[i] <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      pause_q       <= 1'b0;
      ovf_q         <= 1'b0;
      drop_cnt_q    <= '0;
      retrans_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      if (push_c) mem_q[wptr_q] <= push_data_c;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      pause_q       <= pause_d;
      ovf_q         <= ovf_d;
      drop_cnt_q    <= drop_cnt_d;
      retrans_cnt_q <= retrans_cnt_d;
      err_q         <= rx_error_i;
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign rx_pause_o      = pause_q;
  assign overflow_o      = ovf_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign retrans_cnt_o   = retrans_cnt_q;

endmodule
